// File: rtl/booth_seq_mult.sv
`timescale 1ns/1ps
// booth_seq_mult.sv
//
// Sequential radix-2 Booth signed multiplier. One Booth step is retired per
// clock through a single (N+1)-bit ripple adder/subtractor built from
// booth_fa cells. To subtract, the adder inverts M and sets carry-in to 1.
//
// Ports (booth_seq_mult):
//   clk           in   1    single clock, rising edge
//   reset         in   1    synchronous, active-high; clears all state
//   start         in   1    request, accepted only while ready=1
//   multiplicand  in   N    signed M, sampled on the accepting edge
//   multiplier    in   N    signed Q, sampled on the accepting edge
//   ready         out  1    IDLE or DONE; a start would be accepted
//   busy          out  1    STEP in progress
//   done          out  1    single-cycle pulse, product valid
//   product       out  2N   signed M*Q, held until the next completion
//
// Ports (booth_fa):
//   a, b, cin     in   1    addend bits and carry-in
//   sum, cout     out  1    sum bit and carry-out

module booth_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// state | meaning
// IDLE  | waiting for start, ready=1
// STEP  | one Booth add/sub/skip + arithmetic shift per clock, busy=1
// DONE  | product just written, done=1 for one cycle, ready=1 (back-to-back ok)
module booth_seq_mult #(
  parameter int N = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [N-1:0]     multiplicand,
  input  logic [N-1:0]     multiplier,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [2*N-1:0]   product
);
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [N:0]       a_q, a_d;
  logic [N-1:0]     q_q, q_d;
  logic             q_m1_q, q_m1_d;
  logic [N:0]       m_q, m_d;
  logic [CW-1:0]    count_q, count_d;
  logic [2*N-1:0]   product_q, product_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;

  // Booth decision from {Q[0], Q-1}: 01 adds M, 10 subtracts M, else skip.
  logic             add_op;
  logic             sub_op;
  logic [N:0]       addend;
  logic [N:0]       sum;
  logic [N:0]       carry;

  assign add_op   = ~q_q[0] &  q_m1_q;
  assign sub_op   =  q_q[0] & ~q_m1_q;
  assign addend   = sub_op ? ~m_q : m_q;
  assign carry[0] = sub_op;

  for (genvar i = 0; i < N; i++) begin : g_fa
    booth_fa u_fa (
      .a    (a_q[i]),
      .b    (addend[i]),
      .cin  (carry[i]),
      .sum  (sum[i]),
      .cout (carry[i+1])
    );
  end

  // A is one bit wider than the operands, so A-M cannot overflow even for
  // M = -2^(N-1); the carry out of the top bit carries no information.
  assign sum[N] = a_q[N] ^ addend[N] ^ carry[N];

  // Arithmetic right shift of {A', Q, Q-1} by one.
  logic [N:0]       a_step;
  logic [N:0]       a_sh;
  logic [N-1:0]     q_sh;

  assign a_step = (add_op | sub_op) ? sum : a_q;
  assign a_sh   = {a_step[N], a_step[N:1]};
  assign q_sh   = {a_step[0], q_q[N-1:1]};

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    q_d       = q_q;
    q_m1_d    = q_m1_q;
    m_d       = m_q;
    count_d   = count_q;
    product_d = product_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          m_d     = {multiplicand[N-1], multiplicand};
          q_d     = multiplier;
          a_d     = '0;
          q_m1_d  = 1'b0;
          count_d = '0;
          state_d = STEP;
        end else begin
          state_d = IDLE;
        end
      end
      STEP: begin
        a_d     = a_sh;
        q_d     = q_sh;
        q_m1_d  = q_q[0];
        count_d = count_q + CW'(1);
        if (count_q == LAST_STEP) begin
          product_d = {a_sh[N-1:0], q_sh};
          state_d   = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered versions of the next-state decode.
    ready_d = (state_d != STEP);
    busy_d  = (state_d == STEP);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      a_q       <= '0;
      q_q       <= '0;
      q_m1_q    <= 1'b0;
      m_q       <= '0;
      count_q   <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      q_q       <= q_d;
      q_m1_q    <= q_m1_d;
      m_q       <= m_d;
      count_q   <= count_d;
      product_q <= product_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
    end
  end

  assign ready   = ready_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule
